serial_frame_scheduler: RTL

- Transmit-side scheduler for the multi-channel serial link.
- Arbitrates round-robin among NCH requesters and serialises one frame at a time onto a single line.
- Frame format: start bit 0, port id (PORT_W bits, MSB first), length L (LEN_W bits, MSB first), then L data bits (MSB first, data[L-1] down to data[0]).
- Bit timing is paced by the shared clk_en tick; the line idles high.

---
 rtl/serial_frame_scheduler_pkg.sv | 23 ++
 rtl/serial_frame_scheduler_rr_arbiter.sv | 33 +++
 rtl/serial_frame_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_frame_scheduler_pkg.sv
// Shared types and constants for the serial frame link.
// The scheduler and the receive side both use these.
package serial_frame_scheduler_pkg;

  localparam int unsigned DEF_NCH   = 4;
  localparam int unsigned DEF_LEN_W = 4;

  // PORT and LEN are sent back to back as one header field, so they share ST_HDR.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_HDR   = 2'b10,
    ST_DATA  = 2'b11
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter. It scans upward from ptr+1 and wraps modulo NCH.
module rr_arbiter
  import serial_frame_scheduler_pkg::*;
#(
  parameter int unsigned NCH    = DEF_NCH,
  parameter int unsigned PORT_W = clog2(NCH)
) (
  input  logic [NCH-1:0]    req,
  input  logic [PORT_W-1:0] ptr,
  output logic [NCH-1:0]    gnt,
  output logic [PORT_W-1:0] idx,
  output logic              valid
);

  logic [PORT_W-1:0] cand;

  // NCH is a power of two, so truncating to PORT_W bits performs the modulo wrap.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = ptr + PORT_W'(k);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_frame_scheduler.sv
// Transmit scheduler. It arbitrates among NCH requesters and serialises one frame at a time:
// a start bit, then the port id, then the length, then the payload, paced by clk_en.
module serial_frame_scheduler
  import serial_frame_scheduler_pkg::*;
#(
  parameter int unsigned NCH   = DEF_NCH,
  parameter int unsigned LEN_W = DEF_LEN_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clk_en,
  input  logic [NCH-1:0]                      req,
  input  logic [NCH*LEN_W-1:0]                len_in,
  input  logic [NCH*((2**LEN_W)-1)-1:0]       data_in,
  output logic [NCH-1:0]                      gnt,
  output logic                                ser_out,
  output logic                                busy,
  output logic                                frame_done,
  output logic [clog2(NCH)-1:0]               cur_port
);

  localparam int unsigned PORT_W = clog2(NCH);
  localparam int unsigned DATA_W = (2**LEN_W) - 1;
  localparam int unsigned HDR_W  = PORT_W + LEN_W;
  localparam int unsigned CNT_W  = (clog2(DATA_W + 1) > clog2(HDR_W)) ? clog2(DATA_W + 1) : clog2(HDR_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_m1;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d, len_m1;
  logic                ser_q, ser_d;
  logic [PORT_W-1:0]   ptr_q, ptr_d;
  logic [PORT_W-1:0]   port_q, port_d;

  logic [NCH-1:0]      arb_gnt;
  logic [PORT_W-1:0]   arb_idx;
  logic                arb_valid;

  rr_arbiter #(.NCH(NCH), .PORT_W(PORT_W)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign cnt_m1   = cnt_q - 1'b1;
  assign len_m1   = len_q - 1'b1;
  assign ser_out  = ser_q;
  assign busy     = (state_q != ST_IDLE);
  assign cur_port = port_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    data_d     = data_q;
    len_d      = len_q;
    ser_d      = ser_q;
    ptr_d      = ptr_q;
    port_d     = port_q;
    gnt        = '0;
    frame_done = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          // Reset gates the grant so that no pulse escapes while rst is asserted.
          if (arb_valid && rst) begin
            gnt     = arb_gnt;
            ptr_d   = arb_idx;
            port_d  = arb_idx;
            len_d   = len_in[arb_idx*LEN_W +: LEN_W];
            data_d  = data_in[arb_idx*DATA_W +: DATA_W];
            hdr_d   = {arb_idx, len_in[arb_idx*LEN_W +: LEN_W]};
            ser_d   = 1'b0;
            state_d = ST_START;
          end
        end
        ST_START: begin
          ser_d   = hdr_q[HDR_W-1];
          hdr_d   = hdr_q << 1;
          cnt_d   = CNT_W'(HDR_W - 1);
          state_d = ST_HDR;
        end
        ST_HDR: begin
          if (cnt_q != '0) begin
            ser_d = hdr_q[HDR_W-1];
            hdr_d = hdr_q << 1;
            cnt_d = cnt_m1;
          end else if (len_q != '0) begin
            ser_d   = data_q[len_m1];
            cnt_d   = CNT_W'(len_m1);
            state_d = ST_DATA;
          end else begin
            ser_d      = 1'b1;
            state_d    = ST_IDLE;
            frame_done = 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) begin
            ser_d = data_q[cnt_m1];
            cnt_d = cnt_m1;
          end else begin
            ser_d      = 1'b1;
            state_d    = ST_IDLE;
            frame_done = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      ser_q   <= 1'b1;
      ptr_q   <= PORT_W'(NCH - 1);
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      ser_q   <= ser_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
    end
  end

endmodule
